// File: rtl/pipe_pkg.sv
// Shared pipeline types and constants for the fetch/decode boundary.
package pipe_pkg;
  localparam int INSTR_W = 16;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 16'h0800;
  localparam logic [4:0] OPC_HALT = 5'b00000;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [INSTR_W-1:0] pc_inc;
  } ifid_entry_t;

  function automatic logic is_halt(input logic [INSTR_W-1:0] instr);
    return instr[15:11] == OPC_HALT;
  endfunction
endpackage

// File: rtl/ifid_fifo2.sv
// Two-entry circular store with head pointer and occupancy count.
// Push and pop are assumed pre-gated by the caller; clear wins over both.
module ifid_fifo2
  import pipe_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic        pop,
  input  logic        clear,
  input  ifid_entry_t wdata,
  output ifid_entry_t head,
  output logic [1:0]  count
);

  ifid_entry_t mem_q [DEPTH];
  ifid_entry_t mem_d [DEPTH];
  logic        head_q, head_d;
  logic [1:0]  count_q, count_d;
  logic        do_push, do_pop, tail;

  assign do_push = push && !clear && (count_q != 2'd2);
  assign do_pop  = pop  && !clear && (count_q != 2'd0);
  assign tail    = head_q ^ count_q[0];

  always_comb begin
    for (int i = 0; i < DEPTH; i++) mem_d[i] = mem_q[i];
    if (do_push) mem_d[tail] = wdata;
  end

  always_comb begin
    head_d  = head_q;
    count_d = count_q;
    if (clear) begin
      head_d  = 1'b0;
      count_d = 2'd0;
    end else begin
      if (do_pop) head_d = ~head_q;
      // Simultaneous push/pop leaves the count alone; at count 1 the
      // freshly written slot is exactly where the head moves to.
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + 2'd1;
        2'b01:   count_d = count_q - 2'd1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q  <= 1'b0;
      count_q <= 2'd0;
    end else begin
      head_q  <= head_d;
      count_q <= count_d;
    end
  end

  assign head  = mem_q[head_q];
  assign count = count_q;

endmodule

// File: rtl/if_id_buffer.sv
// IF/ID buffer: push/pop gating, flush priority, HALT capture, NOP on empty.
// Optional idle-cycle counter enabled by `define IFID_BUBBLE_CNT_EN.
module if_id_buffer #(
  parameter int          DEPTH     = 2,
  parameter logic [15:0] NOP_INSTR = 16'h0800
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic [15:0] pc_inc_in,
  input  logic        valid_in,
  input  logic        stall,
  input  logic        flush,
  output logic [15:0] instr_out,
  output logic [15:0] pc_inc_out,
  output logic        valid_out,
  output logic        full,
`ifdef IFID_BUBBLE_CNT_EN
  output logic [15:0] bubble_cnt,
`endif
  output logic        halt_pending
);
  import pipe_pkg::*;

  ifid_entry_t wdata, head;
  logic [1:0]  count;
  logic        push, pop;
  logic        halt_q, halt_d;

  assign wdata     = '{instr: instr_in, pc_inc: pc_inc_in};
  assign full      = (count == 2'd2);
  assign valid_out = (count != 2'd0);
  assign push      = valid_in && !full && !flush && !halt_q;
  assign pop       = valid_out && !stall && !flush;

  ifid_fifo2 #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (flush),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

  // Once a HALT is accepted, capture stays closed until a redirect.
  always_comb begin
    halt_d = halt_q;
    if (flush)                         halt_d = 1'b0;
    else if (push && is_halt(instr_in)) halt_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) halt_q <= 1'b0;
    else     halt_q <= halt_d;
  end

  assign halt_pending = halt_q;
  assign instr_out    = valid_out ? head.instr  : NOP_INSTR;
  assign pc_inc_out   = valid_out ? head.pc_inc : 16'h0000;

`ifdef IFID_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt_q, bubble_cnt_d;

  // An empty buffer after a drained HALT is a stopped core, not a bubble.
  always_comb begin
    bubble_cnt_d = bubble_cnt_q;
    if (!valid_out && (!halt_q || count != 2'd0)) bubble_cnt_d = bubble_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) bubble_cnt_q <= 16'd0;
    else     bubble_cnt_q <= bubble_cnt_d;
  end

  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer with a queue-based reference model
// compared every cycle, plus literal expectations at key points.
module tb_if_id_buffer;
  import pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] instr_in = '0, pc_inc_in = '0;
  logic        valid_in = 1'b0, stall = 1'b0, flush = 1'b0;
  logic [15:0] instr_out, pc_inc_out;
  logic        valid_out, full, halt_pending;
`ifdef IFID_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;

  if_id_buffer dut (
    .clk          (clk),
    .rst          (rst),
    .instr_in     (instr_in),
    .pc_inc_in    (pc_inc_in),
    .valid_in     (valid_in),
    .stall        (stall),
    .flush        (flush),
    .instr_out    (instr_out),
    .pc_inc_out   (pc_inc_out),
    .valid_out    (valid_out),
    .full         (full),
`ifdef IFID_BUBBLE_CNT_EN
    .bubble_cnt   (bubble_cnt),
`endif
    .halt_pending (halt_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an ordered queue of entries plus a halt flag.
  ifid_entry_t mq[$];
  bit          m_halt;
  logic [15:0] m_bub;
  bit          m_push, m_pop;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      m_halt = 0;
      m_bub  = '0;
    end else begin
      if (mq.size() == 0 && (!m_halt || mq.size() != 0)) m_bub = m_bub + 16'd1;
      if (flush) begin
        mq.delete();
        m_halt = 0;
      end else begin
        m_pop  = (mq.size() != 0) && !stall;
        m_push = valid_in && (mq.size() < 2) && !m_halt;
        if (m_pop) void'(mq.pop_front());
        if (m_push) begin
          mq.push_back('{instr: instr_in, pc_inc: pc_inc_in});
          if (instr_in[15:11] == 5'b00000) m_halt = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("valid_out",    {31'd0, valid_out},    {31'd0, mq.size() != 0});
      chk("full",         {31'd0, full},         {31'd0, mq.size() == 2});
      chk("halt_pending", {31'd0, halt_pending}, {31'd0, m_halt});
      chk("instr_out",    {16'd0, instr_out},    {16'd0, (mq.size() != 0) ? mq[0].instr  : 16'h0800});
      chk("pc_inc_out",   {16'd0, pc_inc_out},   {16'd0, (mq.size() != 0) ? mq[0].pc_inc : 16'h0000});
`ifdef IFID_BUBBLE_CNT_EN
      chk("bubble_cnt",   {16'd0, bubble_cnt},   {16'd0, m_bub});
`endif
    end
  end

  task automatic drive(input logic vi, input logic [15:0] ins, input logic [15:0] pc,
                       input logic st, input logic fl);
    valid_in = vi; instr_in = ins; pc_inc_in = pc; stall = st; flush = fl;
  endtask

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic lit(input string name, input logic [15:0] ins, input logic v, input logic f);
    chk({name, "_instr"}, {16'd0, instr_out}, {16'd0, ins});
    chk({name, "_valid"}, {31'd0, valid_out}, {31'd0, v});
    chk({name, "_full"},  {31'd0, full},      {31'd0, f});
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #3;
    lit("reset", 16'h0800, 1'b0, 1'b0);
    chk("reset_pc",   {16'd0, pc_inc_out}, 32'd0);
    chk("reset_halt", {31'd0, halt_pending}, 32'd0);
    @(posedge clk); #2;
    rst = 1'b0;

    repeat (5) tick();
    lit("idle", 16'h0800, 1'b0, 1'b0);
`ifdef IFID_BUBBLE_CNT_EN
    chk("bubble_idle5", {16'd0, bubble_cnt}, 32'd5);
`endif

    // Streaming, no stall
    drive(1, 16'h4001, 16'h0002, 0, 0); tick();
    lit("s1", 16'h4001, 1'b1, 1'b0);
    chk("s1_pc", {16'd0, pc_inc_out}, 32'h0002);
    drive(1, 16'h4002, 16'h0004, 0, 0); tick();
    lit("s2", 16'h4002, 1'b1, 1'b0);
    chk("s2_pc", {16'd0, pc_inc_out}, 32'h0004);
    drive(0, 16'h0, 16'h0, 0, 0); tick();
    lit("s3", 16'h0800, 1'b0, 1'b0);

    // Stall onset, extra push ignored, drain on release
    drive(1, 16'hA001, 16'h0010, 1, 0); tick();
    lit("st1", 16'hA001, 1'b1, 1'b0);
    drive(1, 16'hA002, 16'h0012, 1, 0); tick();
    lit("st2", 16'hA001, 1'b1, 1'b1);
    drive(1, 16'hA003, 16'h0014, 1, 0); tick();
    lit("st3", 16'hA001, 1'b1, 1'b1);
    drive(0, 16'h0, 16'h0, 0, 0); tick();
    lit("rel1", 16'hA002, 1'b1, 1'b0);
    tick();
    lit("rel2", 16'h0800, 1'b0, 1'b0);

    // Flush at count 2 drops the same-cycle push
    drive(1, 16'hC001, 16'h0020, 1, 0); tick();
    drive(1, 16'hC002, 16'h0022, 1, 0); tick();
    lit("pre_fl", 16'hC001, 1'b1, 1'b1);
    drive(1, 16'hB000, 16'h0030, 0, 1); tick();
    lit("fl", 16'h0800, 1'b0, 1'b0);
    drive(0, 16'h0, 16'h0, 0, 0); tick();
    lit("fl2", 16'h0800, 1'b0, 1'b0);

    // HALT capture
    drive(1, 16'h0000, 16'h0040, 1, 0); tick();
    lit("halt1", 16'h0000, 1'b1, 1'b0);
    chk("halt1_p", {31'd0, halt_pending}, 32'd1);
    drive(1, 16'h4005, 16'h0042, 0, 0); tick();
    lit("halt2", 16'h0800, 1'b0, 1'b0);
    chk("halt2_p", {31'd0, halt_pending}, 32'd1);
    drive(0, 16'h0, 16'h0, 0, 1); tick();
    chk("halt_flush", {31'd0, halt_pending}, 32'd0);
    drive(1, 16'h4006, 16'h0050, 0, 0); tick();
    lit("post_halt", 16'h4006, 1'b1, 1'b0);

    // Asynchronous reset mid-stream
    drive(1, 16'hD001, 16'h0060, 1, 0); tick();
    drive(1, 16'hD002, 16'h0062, 1, 0); tick();
    lit("pre_rst", 16'h4006, 1'b1, 1'b1);
    drive(0, 16'h0, 16'h0, 0, 0);
    #1 rst = 1'b1;
    #1;
    lit("async_rst", 16'h0800, 1'b0, 1'b0);
`ifdef IFID_BUBBLE_CNT_EN
    chk("bubble_rst", {16'd0, bubble_cnt}, 32'd0);
`endif
    @(posedge clk); #2;
    rst = 1'b0;
    drive(1, 16'hE001, 16'h0070, 0, 0); tick();
    lit("first_after_rst", 16'hE001, 1'b1, 1'b0);

    // Mixed traffic checked by the model only
    for (int i = 0; i < 80; i++) begin
      drive(($urandom % 4) != 0, 16'($urandom), 16'($urandom),
            ($urandom % 3) == 0, ($urandom % 12) == 0);
      tick();
    end
    drive(0, 16'h0, 16'h0, 0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/if_id_buffer.md
# if_id_buffer

Two-entry instruction buffer between the fetch stage and decode, acting as the IF/ID pipeline register. It captures each fetched instruction together with its incremented PC, keeps the decode-side output steady while decode stalls, and absorbs one extra instruction that fetch issues in the stall cycle. Its `full` output is fetch's backpressure. Branch redirects flush the buffer, and a fetched HALT stops further capture.

## Interface
- `DEPTH`, 2: number of entries; fixed at 2, a parameter only for readability.
- `NOP_INSTR`, 16'h0800: value driven on `instr_out` when no valid entry is present.
- `clk` input 1: the single clock.
- `rst` input 1: asynchronous, active-high reset.
- `instr_in` input 16: instruction from fetch.
- `pc_inc_in` input 16: PC+2 from fetch, paired with `instr_in`.
- `valid_in` input 1: fetch presents a real instruction this cycle (low while the IM is busy or the address mismatches).
- `stall` input 1: decode cannot consume the head entry this cycle.
- `flush` input 1: branch taken (`take_branch_PC`); discard all entries.
- `instr_out` output 16: head instruction, or `NOP_INSTR` when empty.
- `pc_inc_out` output 16: head PC+2, or 16'h0000 when empty.
- `valid_out` output 1: the head entry is valid.
- `full` output 1: both entries are occupied; fetch must hold its PC.
- `halt_pending` output 1: a HALT (`instr_in[15:11]` = 5'b00000) has been captured.

## Operation
- State: two entries {instr, pc_inc}, a head pointer (1 bit), a count (0–2) and a `halt_pending` flag.
- Push condition: `valid_in & ~full & ~flush & ~halt_pending`.
- Pop condition: `valid_out & ~stall & ~flush`.
- Push and pop in the same cycle:
  - count is unchanged;
  - at count 1, the new entry becomes the head on the next cycle.
- Push at count 2 cannot happen, because `full` gates it. Input is ignored at count 2 regardless of `valid_in`.
- `flush`:
  - next cycle: count = 0 and `halt_pending` = 0;
  - any same-cycle push is dropped;
  - flush has priority over push, pop and halt capture.
- HALT capture:
  - a pushed instruction whose opcode is 5'b00000 sets `halt_pending` on the next cycle;
  - the HALT entry itself is stored and drained normally;
  - all later pushes are dropped until `flush` or `rst`.
- Outputs are driven combinationally from the registered head entry and count. There is no combinational path from `instr_in` to `instr_out`.
- `full` = (count == 2) and is derived only from registered state.

## Timing
- Reset values (asynchronous, while `rst` is high):
  - count 0 and head pointer 0;
  - `instr_out` = 16'h0800, `pc_inc_out` = 0;
  - `valid_out` = 0, `full` = 0, `halt_pending` = 0;
  - entry storage need not be cleared.
- Latency: an instruction pushed in cycle N appears on `instr_out` in cycle N+1 if the buffer was empty or the sole entry popped in cycle N.
- Under stall: the head stays stable for as many cycles as `stall` is high.
- Throughput: one instruction per cycle with no stall.
- Stall onset: at most one further push lands (count 1→2), then `full` rises.
- Stall release at count 2: one pop per cycle; `full` falls the cycle after the first pop.
- Reset asserted mid-stream: all entries are discarded immediately; the first push is accepted in the first cycle after `rst` deasserts.
- `flush` and `rst` high together: identical result.

## Configuration
- `IFID_BUBBLE_CNT_EN`:
  - when defined, adds output `bubble_cnt` [15:0];
  - it increments in every cycle where `valid_out` = 0 and the processor is not halted (`halt_pending` = 0 or count ≠ 0);
  - it wraps 16'hFFFF → 0 and resets to 0;
  - it is not cleared by `flush`.
- When undefined: no port and no counter logic; all other behaviour is identical.

## Structure
- Shared package `pipe_pkg` holds:
  - `INSTR_W` = 16;
  - `NOP_INSTR` = 16'h0800;
  - `OPC_HALT` = 5'b00000;
  - struct `ifid_entry_t` {instr, pc_inc}.
- One sub-module, `ifid_fifo2`: the 2-entry storage, head pointer and count, with push/pop/clear inputs.
- The top level adds push/pop gating, flush priority, HALT capture, NOP substitution and the optional counter.

## Test plan
- Reset, then no `valid_in` → `instr_out` = 16'h0800, `pc_inc_out` = 0, `valid_out` = 0, `full` = 0.
- Stream 16'h4001/16'h0002, 16'h4002/16'h0004 with `stall` = 0 → each appears one cycle later, in order; `full` never asserts.
- Hold `stall` high while pushing 16'hA001, 16'hA002, 16'hA003:
  - `full` = 1 after the second push;
  - 16'hA003 is ignored;
  - `instr_out` holds 16'hA001;
  - on release, 16'hA001 then 16'hA002 drain.
- Count 2 with `flush` = 1 and `valid_in` = 1 carrying 16'hB000 → next cycle count 0, `valid_out` = 0, 16'hB000 not stored.
- Push 16'h0000 (HALT), then 16'h4005 → `halt_pending` = 1, HALT is delivered, 16'h4005 is dropped; `flush` clears `halt_pending`.
- With `IFID_BUBBLE_CNT_EN`: 5 idle cycles after reset → `bubble_cnt` = 5; an asynchronous `rst` pulse mid-cycle → 0 immediately.
